// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the round-robin frequency measurement scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package freq_meas_pkg;

    localparam int CH_W   = 4;
    localparam int MAX_CH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DISCARD,
        ACCUM,
        REPORT
    } state_t;

    typedef struct packed {
        logic            timeout;
        logic [CH_W-1:0] ch;
        logic [31:0]     period;
        logic [31:0]     high;
    } res_t;

    // First set mask bit strictly after cur, wrapping over n channels; cur if none set.
    function automatic logic [CH_W-1:0] rr_next(
        input logic [MAX_CH-1:0] mask,
        input logic [CH_W-1:0]   cur,
        input int                n
    );
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] idx;
        logic            found;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = CH_W'((int'(cur) + i) % n);
            if (!found && (i <= n) && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/freq_meas_scheduler_if.sv
// Capture-unit and result buses of the frequency measurement scheduler.
// Latency: n/a (wiring only).
// Backpressure: results use valid/ready; capture side is a free-running pulse bus.
interface freq_meas_scheduler_if;

    logic                          cap_sig;
    logic                          cap_clr;
    logic                          cap_done;
    logic [31:0]                   cap_period;
    logic [31:0]                   cap_high;

    logic                          res_valid;
    logic                          res_ready;
    logic [freq_meas_pkg::CH_W-1:0] res_ch;
    logic [31:0]                   res_period;
    logic [31:0]                   res_high;
    logic                          res_timeout;

    modport master (
        output cap_sig, cap_clr, res_valid, res_ch, res_period, res_high, res_timeout,
        input  cap_done, cap_period, cap_high, res_ready
    );

    modport slave (
        input  cap_sig, cap_clr, res_valid, res_ch, res_period, res_high, res_timeout,
        output cap_done, cap_period, cap_high, res_ready
    );

endinterface

// File: rtl/freq_avg_accum.sv
// Sums 2**AVG_LOG2 period/high samples and presents the shift-divided average.
// Latency: averages are combinational on the sample that completes the set.
// Backpressure: none; the caller decides when samples are added or cleared.
module freq_avg_accum #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [31:0] period,
    input  logic [31:0] high,
    output logic        last,
    output logic [31:0] avg_period,
    output logic [31:0] avg_high
);

    localparam int SW = 32 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    logic [SW-1:0] sum_p;
    logic [SW-1:0] sum_h;
    logic [SW-1:0] sum_p_next;
    logic [SW-1:0] sum_h_next;
    logic [CW-1:0] cnt;

    assign sum_p_next = sum_p + SW'(period);
    assign sum_h_next = sum_h + SW'(high);

    // Set is complete when the sample being added is the AVG_N-th one.
    assign last       = add && (cnt == CW'((1 << AVG_LOG2) - 1));
    assign avg_period = sum_p_next[AVG_LOG2 +: 32];
    assign avg_high   = sum_h_next[AVG_LOG2 +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p <= '0;
            sum_h <= '0;
            cnt   <= '0;
        end else if (clr) begin
            sum_p <= '0;
            sum_h <= '0;
            cnt   <= '0;
        end else if (add) begin
            sum_p <= sum_p_next;
            sum_h <= sum_h_next;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/freq_meas_scheduler.sv
// Round-robin time-sharing of one capture unit over N_CH inputs, averaging each channel.
// Latency: result registered 1 cycle after the last averaged cap_done (or the timeout).
// Backpressure: result held while res_ready is low; capture stays cleared until accepted.
module freq_meas_scheduler
    import freq_meas_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          AVG_LOG2    = 2,
    parameter int          SETTLE_CYC  = 3,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [N_CH-1:0]        chan_mask,
    input  logic [N_CH-1:0]        sig_in,
    freq_meas_scheduler_if.master  bus,
    output logic                   busy
);

    state_t          state;
    logic [CH_W-1:0] cur_ch;
    logic [7:0]      settle_cnt;
    logic [31:0]     to_cnt;
    res_t            res;
    logic            res_valid_q;
    logic            cap_clr_q;

    logic [MAX_CH-1:0] mask_ext;
    logic [CH_W-1:0]   next_ch;
    logic              go;
    logic              meas;
    logic              to_hit;
    logic              acc_clr;
    logic              acc_add;
    logic              acc_last;
    logic [31:0]       avg_p;
    logic [31:0]       avg_h;
    logic              cap_sig_c;

    always_comb begin
        mask_ext             = '0;
        mask_ext[N_CH-1:0]   = chan_mask;
    end

    assign next_ch = rr_next(mask_ext, cur_ch, N_CH);
    assign go      = enable && (chan_mask != '0);
    assign meas    = (state == DISCARD) || (state == ACCUM);
    // A done pulse on the terminal-count cycle still counts as a live signal.
    assign to_hit  = meas && !bus.cap_done && (to_cnt == 32'(TIMEOUT_CYC - 1));
    assign acc_clr = (state == SELECT);
    assign acc_add = (state == ACCUM) && bus.cap_done;

    always_comb begin
        cap_sig_c = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == CH_W'(i)) begin
                cap_sig_c = sig_in[i];
            end
        end
    end

    freq_avg_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (acc_clr),
        .add        (acc_add),
        .period     (bus.cap_period),
        .high       (bus.cap_high),
        .last       (acc_last),
        .avg_period (avg_p),
        .avg_high   (avg_h)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_ch      <= CH_W'(N_CH - 1);
            settle_cnt  <= '0;
            to_cnt      <= '0;
            res         <= '0;
            res_valid_q <= 1'b0;
            cap_clr_q   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state      <= SELECT;
                        cur_ch     <= next_ch;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                SELECT: begin
                    to_cnt <= '0;
                    if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                        state     <= DISCARD;
                        cap_clr_q <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                DISCARD, ACCUM: begin
                    if (bus.cap_done) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                    if (to_hit) begin
                        res         <= '{timeout: 1'b1, ch: cur_ch, period: 32'd0, high: 32'd0};
                        res_valid_q <= 1'b1;
                        cap_clr_q   <= 1'b1;
                        state       <= REPORT;
                    end else if ((state == DISCARD) && bus.cap_done) begin
                        state <= ACCUM;
                    end else if (acc_last) begin
                        res         <= '{timeout: 1'b0, ch: cur_ch, period: avg_p, high: avg_h};
                        res_valid_q <= 1'b1;
                        cap_clr_q   <= 1'b1;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (go) begin
                            state      <= SELECT;
                            cur_ch     <= next_ch;
                            settle_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cap_clr_q <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cap_sig     = cap_sig_c;
    assign bus.cap_clr     = cap_clr_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_ch      = res.ch;
    assign bus.res_period  = res.period;
    assign bus.res_high    = res.high;
    assign bus.res_timeout = res.timeout;

endmodule
